// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage types: bus widths, reset polarity, FSM encodings and the buffered entry layout.
package if_fetch_pkg;

  typedef logic [31:0] InstAddrBus;
  typedef logic [31:0] InstBus;

  localparam InstBus ZeroWord  = 32'h0000_0000;
  localparam logic   RstEnable = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    InstAddrBus pc;
    InstBus     inst;
  } fetch_entry_t;

  function automatic InstAddrBus next_pc(input InstAddrBus pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO with synchronous push/pop/flush; flush wins over push and pop.
// Head data comes from registered storage and is forced to zero while empty.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head_dat,
  output logic                   head_vld,
  output logic [$clog2(DEPTH):0] cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_vld = (cnt_q != '0);
  assign head_dat = head_vld ? mem_q[rd_ptr_q] : '0;
  assign cnt      = cnt_q;

  // A same-cycle pop frees the slot, so only an unpaired push into a full FIFO is illegal.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && cnt_q == CNT_W'(DEPTH)));

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the fetch PC, keeps at most one imem request in flight, buffers words for IF/ID.
// Requests are issued combinationally off the FSM so a latency-1 memory streams one word per cycle.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
);

  localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  fetch_state_e     state_q, state_d;
  InstAddrBus       fetch_pc_q, fetch_pc_d;
  logic             out_en_q, out_en_d;
  logic             push, pop, head_vld;
  logic [CNT_W-1:0] cnt, cnt_after_push;
  InstAddrBus       target;
  fetch_entry_t     push_entry, head_entry;

  assign target         = branch_target_i & ~32'd3;
  assign pop            = head_vld & ~stall_i & ~branch_flag_i;
  assign cnt_after_push = cnt + CNT_W'(1) - CNT_W'(pop);
  assign push_entry     = '{pc: fetch_pc_q, inst: imem_rdata_i};

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    out_en_d    = 1'b1;
    push        = 1'b0;
    imem_req_o  = 1'b0;
    imem_addr_o = ZeroWord;
    case (state_q)
      IDLE: begin
        if (branch_flag_i) begin
          fetch_pc_d = target;
        end else if (out_en_q && cnt < DEPTH_C) begin
          imem_req_o  = 1'b1;
          imem_addr_o = fetch_pc_q;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i && !branch_flag_i) begin
          push       = 1'b1;
          fetch_pc_d = next_pc(fetch_pc_q);
          if (cnt_after_push < DEPTH_C) begin
            imem_req_o  = 1'b1;
            imem_addr_o = next_pc(fetch_pc_q);
          end else begin
            state_d = IDLE;
          end
        end else if (branch_flag_i) begin
          fetch_pc_d = target;
          state_d    = imem_rvalid_i ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        if (branch_flag_i) fetch_pc_d = target;
        if (imem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // out_en_q holds off the first request until a clock edge has seen reset released.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      out_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_en_q   <= out_en_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .flush    (branch_flag_i),
    .head_dat (head_entry),
    .head_vld (head_vld),
    .cnt      (cnt)
  );

  assign if_valid_o = head_vld;
  assign if_pc_o    = head_entry.pc;
  assign if_inst_o  = head_entry.inst;

  assert property (@(posedge clk) disable iff (rst == RstEnable)
    !(state_q == IDLE && imem_rvalid_i));

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: variable-latency memory model plus a program-order stream model.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, branch_flag_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] if_pc_o, if_inst_o;
  logic        if_valid_o;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o),
    .if_valid_o      (if_valid_o)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pending[$];
  int          n_checks = 0, n_pass = 0;
  int          cyc = 0, nreq = 0, consumed = 0;
  int          lat_min = 1, lat_max = 1;
  logic [31:0] exp_pc, exp_req;
  logic        prev_branch = 1'b0, last_req = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // One cycle: drive inputs and any due response at negedge, then check outputs against the model.
  task automatic step(input logic stall, input logic br, input logic [31:0] tgt);
    @(negedge clk);
    cyc++;
    stall_i = stall;
    branch_flag_i = br;
    branch_target_i = tgt;
    if (pending.size() > 0 && pending[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pending[0].addr);
      void'(pending.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    #1;
    if (prev_branch) check("flush_valid", 32'(if_valid_o), 32'd0);
    if (!if_valid_o) begin
      check("nop_pc", if_pc_o, 32'd0);
      check("nop_inst", if_inst_o, 32'd0);
    end else begin
      check("head_pc", if_pc_o, exp_pc);
      check("head_inst", if_inst_o, mem_word(exp_pc));
      if (!stall && !br) begin
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
    end
    last_req = imem_req_o;
    if (imem_req_o) begin
      check("req_addr", imem_addr_o, exp_req);
      check("one_outstanding", 32'(pending.size()), 32'd0);
      pending.push_back('{imem_addr_o, cyc + int'($urandom_range(lat_max, lat_min))});
      exp_req = exp_req + 32'd4;
      nreq++;
    end
    if (br) begin
      exp_pc  = {tgt[31:2], 2'b00};
      exp_req = {tgt[31:2], 2'b00};
    end
    prev_branch = br;
  endtask

  // Called with rst already low: checks async reset values, drives a stale response, releases.
  task automatic reset_body();
    #1;
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_addr", imem_addr_o, 32'd0);
    check("rst_valid", 32'(if_valid_o), 32'd0);
    check("rst_pc", if_pc_o, 32'd0);
    check("rst_inst", if_inst_o, 32'd0);
    pending.delete();
    @(negedge clk);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("release_req", 32'(imem_req_o), 32'd0);
    exp_pc      = RESET_PC;
    exp_req     = RESET_PC;
    prev_branch = 1'b0;
  endtask

  initial begin
    int n0;
    logic found;
    rst = 1'b1;
    stall_i = 1'b0;
    branch_flag_i = 1'b0;
    branch_target_i = 32'd0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = 32'd0;
    #1 rst = 1'b0;
    reset_body();

    // Streaming at latency 1 through the 0xFFFF_FFFC -> 0 wrap; one request per cycle once warm.
    repeat (4) step(1'b0, 1'b0, 32'd0);
    n0 = nreq;
    repeat (16) step(1'b0, 1'b0, 32'd0);
    check("stream_rate", 32'(nreq - n0), 32'd16);

    // Stall long enough to fill the buffer: requests stop, head holds.
    repeat (5) step(1'b1, 1'b0, 32'd0);
    check("stall_req", 32'(imem_req_o), 32'd0);
    check("stall_valid", 32'(if_valid_o), 32'd1);
    repeat (8) step(1'b0, 1'b0, 32'd0);

    // Redirect coincident with a response while one entry is buffered; low target bits dropped.
    step(1'b0, 1'b1, 32'h0000_0203);
    step(1'b0, 1'b0, 32'd0);
    check("redir_addr", imem_addr_o, 32'h0000_0200);
    repeat (6) step(1'b0, 1'b0, 32'd0);

    // Latency 3: redirect the cycle after a request, so its late word must be drained.
    lat_min = 3;
    lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b0, 32'd0);
      found = last_req;
    end
    check("lat3_req_seen", 32'(found), 32'd1);
    step(1'b0, 1'b1, 32'h0000_0100);
    repeat (15) step(1'b0, 1'b0, 32'd0);

    // Asynchronous reset with a request outstanding.
    lat_min = 2;
    lat_max = 2;
    repeat (3) step(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    stall_i = 1'b0;
    branch_flag_i = 1'b0;
    #2 rst = 1'b0;
    reset_body();

    lat_min = 1;
    lat_max = 3;
    repeat (3000)
      step($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 6, $urandom);
    check("progress", 32'(consumed > 300), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
